imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. Receives a program as a byte stream over a valid/ready handshake, packs the bytes into 32-bit little-endian words, and issues one word write per word into instruction memory.
- Holds the RV32 datapath in reset until the load completes.
- Sits between a host or boot byte source and the instruction memory write port, so programs load without the simulation-only file read.

Parameters:
- ADDR_WIDTH, 8, word-index width; capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 32'h0, byte address of word 0 in instruction memory.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE and ERROR.
- lenWords  input  ADDR_WIDTH+1  number of words to load; sampled on the start cycle.
- byteIn  input  8  stream data byte.
- byteValid  input  1  byteIn is valid.
- byteReady  output  1  loader accepts a byte this cycle; a transfer occurs when byteValid & byteReady.
- memWriteEn  output  1  instruction memory write strobe, one cycle per word.
- memAddr  output  32  byte address, BASE_ADDR + 4*wordIdx.
- memWriteData  output  32  assembled word.
- cpuReset  output  1  holds the datapath in reset while high.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.

Behaviour:
- Reset values:
  - state = IDLE; byteReady, memWriteEn, busy, done, error = 0.
  - memAddr = BASE_ADDR; memWriteData = 0; cpuReset = 1.
  - Internal byte counter = 0, word counter = 0, shift register = 0.
- FSM states: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE, on start:
  - lenWords == 0 or lenWords > 2**ADDR_WIDTH → ERROR.
  - Otherwise latch lenWords, clear counters → COLLECT.
- COLLECT:
  - byteReady = 1.
  - Each transfer places byte k (k = 0..3) into bits [8k+7:8k], little-endian, and increments the byte counter.
  - The transfer with k = 3 → WRITE next cycle.
  - byteValid low stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - byteReady = 0, memWriteEn = 1.
  - memAddr = BASE_ADDR + {wordIdx, 2'b00}; memWriteData = assembled word.
  - Next: wordIdx+1 == latched length → DONE; otherwise wordIdx increments → COLLECT.
- Throughput: at most one byte per cycle, so the minimum load time is 5*lenWords cycles from the first accepted byte.
- DONE:
  - done = 1, cpuReset = 0.
  - Stays in DONE until start (revalidated as in IDLE) or reset.
  - start in DONE re-asserts cpuReset from the next cycle.
- ERROR:
  - error = 1, cpuReset = 1, no writes.
  - Exits only on a valid start (→ COLLECT) or on reset.
- cpuReset is 0 only in DONE.
- memWriteEn is never high outside WRITE.
- start during COLLECT or WRITE is ignored; the latched length is unchanged.
- Address arithmetic is 32-bit modulo; wordIdx never exceeds latched length − 1.
- Reset mid-load (any state):
  - Next cycle is IDLE with reset values.
  - The partial word is discarded and no write is issued in that cycle.
  - Words already written are not rolled back.
- reset and start together: reset wins.
- Bytes presented outside COLLECT are not accepted (byteReady = 0) and are not consumed.

Test Plan:
- Single word: reset, start with lenWords=1, bytes 13,00,50,00 back-to-back → one memWriteEn pulse with memAddr=0x0 and memWriteData=0x00500013, four cycles after the first byte. Next cycle done=1 and cpuReset=0.
- Multi-word with stalls: lenWords=3, BASE_ADDR=0x100, byteValid toggled every other cycle → writes to 0x100, 0x104, 0x108 with the correct words, no extra writes, and byteReady=0 during each WRITE cycle.
- Bad length: start with lenWords=0 → error=1, cpuReset=1, no writes. Then start with lenWords=2 → normal load, error clears.
- Reset mid-word: lenWords=2, two bytes accepted, then reset pulsed → no memWriteEn, state IDLE, cpuReset=1. A fresh load of 8 bytes then writes only the new words at 0x0 and 0x4.
- Ignored start: start pulsed during COLLECT with lenWords=5 while loading 2 words → exactly 2 writes, then DONE.
- Capacity boundary: ADDR_WIDTH=2, lenWords=4 → last write at memAddr=0xC, then DONE. lenWords=5 → ERROR.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes them to instruction memory,
// holding the datapath in reset until the load completes.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   lenWords,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  memWriteEn,
    output logic [31:0]           memAddr,
    output logic [31:0]           memWriteData,
    output logic                  cpuReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [1:0]            byte_q;
    logic [31:0]           shift_q, shift_d;
    logic                  xfer, len_ok, last_word;
    always_comb begin
        xfer      = byteValid && byteReady;
        len_ok    = lenWords != '0 && lenWords <= CAP;
        last_word = {1'b0, word_q} + 1'b1 == len_q;
        shift_d   = shift_q;
        shift_d[8*byte_q +: 8] = byteIn;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_q       <= '0;
            byte_q       <= '0;
            shift_q      <= '0;
            byteReady    <= 1'b0;
            memWriteEn   <= 1'b0;
            memAddr      <= BASE_ADDR;
            memWriteData <= '0;
            cpuReset     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            memWriteEn <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: if (start) begin
                    state_q   <= len_ok ? COLLECT : ERROR;
                    len_q     <= len_ok ? lenWords : len_q;
                    word_q    <= '0;
                    byte_q    <= '0;
                    shift_q   <= '0;
                    byteReady <= len_ok;
                    busy      <= len_ok;
                    error     <= !len_ok;
                    done      <= 1'b0;
                    cpuReset  <= 1'b1;
                end
                COLLECT: if (xfer) begin
                    shift_q <= shift_d;
                    byte_q  <= byte_q + 1'b1;
                    if (byte_q == 2'd3) begin
                        state_q      <= WRITE;
                        byteReady    <= 1'b0;
                        memWriteEn   <= 1'b1;
                        memAddr      <= BASE_ADDR + 32'({word_q, 2'b00});
                        memWriteData <= shift_d;
                    end
                end
                WRITE: begin
                    state_q   <= last_word ? DONE : COLLECT;
                    word_q    <= last_word ? word_q : word_q + 1'b1;
                    byteReady <= !last_word;
                    busy      <= !last_word;
                    done      <= last_word;
                    cpuReset  <= !last_word;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checked by an independent monitor.
module tb_imem_loader;
    localparam int          AW   = 2;
    localparam logic [31:0] BASE = 32'h100;
    logic clock = 0, reset = 1, start = 0, byteValid = 0;
    logic [AW:0] lenWords = '0;
    logic [7:0] byteIn = '0;
    logic byteReady, memWriteEn, cpuReset, busy, done, error;
    logic [31:0] memAddr, memWriteData;
    logic [63:0] exp_q[$];
    logic [31:0] wd[8];
    int vectors = 0, miscompares = 0;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .start(start), .lenWords(lenWords),
        .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .memWriteEn(memWriteEn), .memAddr(memAddr), .memWriteData(memWriteData),
        .cpuReset(cpuReset), .busy(busy), .done(done), .error(error));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clock) if (memWriteEn) begin
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", memAddr, memWriteData);
        end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", memAddr, e[63:32]);
            chk("wr_data", memWriteData, e[31:0]);
            chk("wr_ready_low", 32'(byteReady), 32'd0);
            chk("wr_cpu_reset", 32'(cpuReset), 32'd1);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int len);
        start = 1;
        lenWords = AW'(len) + '0;
        lenWords = len[AW:0];
        cyc();
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byteValid = 0;
        repeat (gap) cyc();
        byteValid = 1;
        byteIn = b;
        while (!byteReady && n < 50) begin
            cyc();
            n++;
        end
        chk("byte_accept", 32'(byteReady), 32'd1);
        cyc();
        byteValid = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            cyc();
            n++;
        end
        chk("done", 32'(done), 32'd1);
        chk("done_cpu_reset", 32'(cpuReset), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic load(input int len, input int gap);
        pulse_start(len);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_error", 32'(error), 32'd0);
        chk("load_cpu_reset", 32'(cpuReset), 32'd1);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({BASE + 32'(4 * i), wd[i]});
            send_word(wd[i], gap);
        end
        wait_done();
    endtask

    initial begin
        repeat (3) cyc();
        reset = 0;
        chk("rst_cpu_reset", 32'(cpuReset), 32'd1);
        chk("rst_ready", 32'(byteReady), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_addr", memAddr, BASE);
        chk("rst_data", memWriteData, 32'd0);

        // Single word, back-to-back bytes: strobe right after the fourth byte.
        pulse_start(1);
        exp_q.push_back({BASE, 32'h00500013});
        send_word(32'h00500013, 0);
        chk("single_strobe", 32'(memWriteEn), 32'd1);
        cyc();
        chk("single_done", 32'(done), 32'd0 + 32'd1);
        chk("single_cpu_reset", 32'(cpuReset), 32'd0);

        // Bytes offered in DONE are not consumed.
        byteValid = 1;
        byteIn = 8'hAA;
        repeat (3) cyc();
        chk("done_no_ready", 32'(byteReady), 32'd0);
        byteValid = 0;

        // Multi-word with every-other-cycle stalls; start from DONE re-asserts cpuReset.
        wd[0] = 32'h11223344; wd[1] = 32'hDEADBEEF; wd[2] = 32'h0BADF00D;
        load(3, 1);

        // Zero length is rejected, then a valid load recovers.
        pulse_start(0);
        chk("bad0_error", 32'(error), 32'd1);
        chk("bad0_cpu_reset", 32'(cpuReset), 32'd1);
        chk("bad0_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        wd[0] = 32'hCAFEBABE; wd[1] = 32'h01234567;
        load(2, 0);

        // Reset mid-word discards the partial word.
        pulse_start(2);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1;
        cyc();
        reset = 0;
        chk("midrst_cpu_reset", 32'(cpuReset), 32'd1);
        chk("midrst_flags", {28'd0, byteReady, busy, done, error}, 32'd0);
        chk("midrst_addr", memAddr, BASE);
        repeat (2) cyc();
        chk("midrst_no_write", 32'(exp_q.size()), 32'd0);
        wd[0] = 32'h89ABCDEF; wd[1] = 32'h76543210;
        load(2, 0);

        // start during COLLECT is ignored; length stays at 2.
        pulse_start(2);
        exp_q.push_back({BASE, 32'hA1B2C3D4});
        exp_q.push_back({BASE + 32'd4, 32'h5E6F7081});
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        pulse_start(5);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_error", 32'(error), 32'd0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_word(32'h5E6F7081, 0);
        wait_done();

        // Full capacity, then one word over.
        wd[0] = 32'h00000001; wd[1] = 32'h00000002; wd[2] = 32'h00000003; wd[3] = 32'hFFFFFFFF;
        load(4, 0);
        pulse_start(5);
        chk("over_error", 32'(error), 32'd1);
        chk("over_cpu_reset", 32'(cpuReset), 32'd1);
        chk("over_done", 32'(done), 32'd0);
        repeat (4) cyc();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
